msrv32_dec: RTL and testbench
=============================

// Module: msrv32_dec
// PURPOSE
//  RV32I instruction decoder for the msrv32 core. It sits between instruction fetch/immediate
//  generation and the ALU, LSU, CSR and writeback blocks. It turns opcode/funct fields and the
//  low address bits from the immediate adder into registered control signals plus
//  illegal-instruction and misaligned-access flags.
// PARAMETERS
//  none (encodings are fixed constants in msrv32_pkg)
// PORTS
//  clk_in                 in   1  system clock; all outputs update on the rising edge
//  rst_in                 in   1  reset, synchronous, active-low
//  opcode_in              in   7  instr[6:0]
//  funct7_5_in            in   1  instr[30]
//  funct3_in              in   3  instr[14:12]
//  iadder_1_to_0_in       in   2  bits [1:0] of the computed effective address
//  trap_taken_in          in   1  trap this cycle; suppresses architectural side effects
//  alu_opcode_out         out  4  {alt bit, funct3}; 0000 = ADD
//  mem_wr_req_out         out  1  store request
//  load_size_out          out  2  00 byte, 01 half, 10 word
//  load_unsigned_out      out  1  zero-extend load data
//  alu_src_out            out  1  1 = rs2, 0 = immediate
//  iadder_src_out         out  1  1 = rs1 base, 0 = PC base
//  csr_wr_en_out          out  1  CSR write enable
//  rf_wr_en_out           out  1  register-file write enable
//  wb_mux_sel_out         out  3  writeback source select
//  imm_type_out           out  3  immediate format select
//  csr_op_out             out  3  CSR operation (funct3)
//  illegal_instr_out      out  1  unsupported/illegal encoding
//  misalligned_load_out   out  1  misaligned load address
//  misalligned_store_out  out  1  misaligned store address
// BEHAVIOUR
//  - Decode logic is combinational; every output is registered, so latency is 1 clock.
//  - If rst_in=0 at a rising edge, every output becomes 0 (ADD, no writes, no flags). This
//    also applies mid-operation.
//  - Opcode classes on opcode_in[6:2], valid only when opcode_in[1:0]=11:
//    LOAD 00000, MISC_MEM 00011, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100,
//    LUI 01101, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100.
//  - alu_opcode_out:
//    * OP: {funct7_5, funct3}.
//    * OP_IMM: {funct7_5 & (funct3==101), funct3}.
//    * All other classes: 0000.
//  - alu_src_out = 1 only for OP and BRANCH.
//  - iadder_src_out = 1 for LOAD, STORE and JALR.
//  - load_size_out = funct3[1:0]; load_unsigned_out = funct3[2]. Both are driven for every class.
//  - wb_mux_sel_out:
//    * 000 ALU (OP, OP_IMM)
//    * 001 load data (LOAD)
//    * 010 immediate (LUI)
//    * 011 iadder (AUIPC)
//    * 100 CSR (SYSTEM with funct3!=000)
//    * 101 PC+4 (JAL, JALR)
//    * all other classes: 000
//  - imm_type_out:
//    * 000 R (OP, or none)
//    * 001 I (OP_IMM, LOAD, JALR, SYSTEM with funct3=000)
//    * 010 S (STORE)
//    * 011 B (BRANCH)
//    * 100 U (LUI, AUIPC)
//    * 101 J (JAL)
//    * 110 CSR (SYSTEM with funct3!=000)
//  - csr_op_out = funct3 for SYSTEM, otherwise 000.
//  - Misaligned flags:
//    * misalligned_load_out = LOAD & ((size 10 & addr[1:0]!=00) | (size 01 & addr[0])).
//    * misalligned_store_out uses the same rule for STORE.
//  - illegal_instr_out = 1 for any of:
//    * opcode_in[1:0]!=11, or an unknown class
//    * LOAD with funct3 in {011,110,111}
//    * STORE with funct3>=011
//    * BRANCH with funct3 in {010,011}
//    * JALR with funct3!=000
//    * SYSTEM with funct3=100
//  - When illegal_instr_out=1 or trap_taken_in=1:
//    * mem_wr_req_out, rf_wr_en_out and csr_wr_en_out are forced to 0.
//    * Other outputs still show the raw decode.
//  - rf_wr_en_out = LUI|AUIPC|JAL|JALR|OP|OP_IMM|LOAD|CSR, and 0 on a misaligned load.
//  - mem_wr_req_out = STORE & ~misalligned_store.
//  - csr_wr_en_out = SYSTEM with funct3!=000.
// STRUCTURE
//  - msrv32_pkg holds opcode class constants, the WB_* select codes, the IMM_* type codes
//    and the ALU_* opcode codes.
//  - Single module with no sub-modules: a combinational decode block feeding one output
//    register stage.
// TESTING
//  - Reset: rst_in=0 for 2 clocks with any inputs -> all outputs 0.
//  - ADD/SUB: op=0110011, f3=000, f7_5=1 ->
//    alu 1000, rf_wr 1, alu_src 1, wb 000, imm 000, no flags (next cycle).
//  - SRAI vs ADDI: op=0010011, f7_5=1 ->
//    * f3=101: alu 1101
//    * f3=000: alu 0000
//    * both: imm 001, alu_src 0.
//  - LW alignment: op=0000011, f3=010 ->
//    * addr=00: no flag, wb 001, rf_wr 1.
//    * addr=10: misalligned_load 1, rf_wr 0.
//  - SH with trap: op=0100011, f3=001, addr=00 ->
//    * trap_taken_in=0: mem_wr 1.
//    * trap_taken_in=1: mem_wr 0.
//    * addr=01 (trap 0): misalligned_store 1, mem_wr 0.
//  - CSRRW/illegal:
//    * op=1110011, f3=001 -> csr_wr 1, wb 100, imm 110, csr_op 001.
//    * op=0001100 -> illegal 1, all write enables 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Purpose : shared encodings for the msrv32 decoder: opcode classes, writeback select,
//           immediate format and ALU opcode codes, plus the registered control bundle.
// Ports   : none (package); also provides the misaligned-access helper function.
package msrv32_pkg;

  // Opcode classes, taken from instr[6:2] once instr[1:0] is 11
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // Writeback source select
  localparam logic [2:0] WB_ALU    = 3'b000;
  localparam logic [2:0] WB_LOAD   = 3'b001;
  localparam logic [2:0] WB_IMM    = 3'b010;
  localparam logic [2:0] WB_IADDER = 3'b011;
  localparam logic [2:0] WB_CSR    = 3'b100;
  localparam logic [2:0] WB_PC4    = 3'b101;

  // Immediate format select
  localparam logic [2:0] IMM_R   = 3'b000;
  localparam logic [2:0] IMM_I   = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;

  // ALU opcodes: {alt bit, funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [3:0] alu_opcode;
    logic       mem_wr_req;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       alu_src;
    logic       iadder_src;
    logic       csr_wr_en;
    logic       rf_wr_en;
    logic [2:0] wb_mux_sel;
    logic [2:0] imm_type;
    logic [2:0] csr_op;
    logic       illegal_instr;
    logic       misalligned_load;
    logic       misalligned_store;
  } dec_ctrl_t;

  // Word accesses need addr[1:0]==00, halfword accesses need addr[0]==0
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == 2'b10) && (addr != 2'b00)) || ((size == 2'b01) && addr[0]);
  endfunction

endpackage

// File: rtl/msrv32_dec.sv
// Purpose : RV32I instruction decoder; opcode/funct fields + effective address LSBs in,
//           registered ALU/LSU/CSR/writeback controls and illegal/misaligned flags out.
// Latency : 1 clock (combinational decode, single output register stage).
// Backpr. : none; decodes every cycle. Sync active-low rst_in clears all outputs.
// Ports   : clk_in, rst_in; opcode_in, funct7_5_in, funct3_in, iadder_1_to_0_in,
//           trap_taken_in; *_out control and flag outputs.
module msrv32_dec
  import msrv32_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [6:0] opcode_in,
  input  logic       funct7_5_in,
  input  logic [2:0] funct3_in,
  input  logic [1:0] iadder_1_to_0_in,
  input  logic       trap_taken_in,
  output logic [3:0] alu_opcode_out,
  output logic       mem_wr_req_out,
  output logic [1:0] load_size_out,
  output logic       load_unsigned_out,
  output logic       alu_src_out,
  output logic       iadder_src_out,
  output logic       csr_wr_en_out,
  output logic       rf_wr_en_out,
  output logic [2:0] wb_mux_sel_out,
  output logic [2:0] imm_type_out,
  output logic [2:0] csr_op_out,
  output logic       illegal_instr_out,
  output logic       misalligned_load_out,
  output logic       misalligned_store_out
);

  logic       opc_valid;
  logic [4:0] opc_class;
  logic is_load, is_misc_mem, is_op_imm, is_auipc, is_store, is_op;
  logic is_lui, is_branch, is_jalr, is_jal, is_system, is_csr;
  logic known_class;
  logic mis_access;
  logic illegal;
  logic suppress;

  dec_ctrl_t ctrl_d;
  dec_ctrl_t ctrl_q;

  // Non-32-bit encodings (low bits != 11) match no class at all
  assign opc_valid   = (opcode_in[1:0] == 2'b11);
  assign opc_class   = opcode_in[6:2];
  assign is_load     = opc_valid && (opc_class == OPC_LOAD);
  assign is_misc_mem = opc_valid && (opc_class == OPC_MISC_MEM);
  assign is_op_imm   = opc_valid && (opc_class == OPC_OP_IMM);
  assign is_auipc    = opc_valid && (opc_class == OPC_AUIPC);
  assign is_store    = opc_valid && (opc_class == OPC_STORE);
  assign is_op       = opc_valid && (opc_class == OPC_OP);
  assign is_lui      = opc_valid && (opc_class == OPC_LUI);
  assign is_branch   = opc_valid && (opc_class == OPC_BRANCH);
  assign is_jalr     = opc_valid && (opc_class == OPC_JALR);
  assign is_jal      = opc_valid && (opc_class == OPC_JAL);
  assign is_system   = opc_valid && (opc_class == OPC_SYSTEM);
  assign is_csr      = is_system && (funct3_in != 3'b000);

  assign known_class = is_load | is_misc_mem | is_op_imm | is_auipc | is_store | is_op |
                       is_lui | is_branch | is_jalr | is_jal | is_system;

  assign mis_access = is_misaligned(funct3_in[1:0], iadder_1_to_0_in);

  assign illegal = !known_class
                 | (is_load   && (funct3_in == 3'b011 || funct3_in == 3'b110 ||
                                  funct3_in == 3'b111))
                 | (is_store  && (funct3_in >= 3'b011))
                 | (is_branch && (funct3_in == 3'b010 || funct3_in == 3'b011))
                 | (is_jalr   && (funct3_in != 3'b000))
                 | (is_system && (funct3_in == 3'b100));

  // Only architectural side effects are killed; the rest shows the raw decode
  assign suppress = illegal | trap_taken_in;

  always_comb begin
    ctrl_d = '0;

    if (is_op) begin
      ctrl_d.alu_opcode = {funct7_5_in, funct3_in};
    end else if (is_op_imm) begin
      // Only SRAI uses the alt bit; for other immediates instr[30] is immediate data
      ctrl_d.alu_opcode = {funct7_5_in & (funct3_in == 3'b101), funct3_in};
    end else begin
      ctrl_d.alu_opcode = ALU_ADD;
    end

    ctrl_d.load_size     = funct3_in[1:0];
    ctrl_d.load_unsigned = funct3_in[2];
    ctrl_d.alu_src       = is_op | is_branch;
    ctrl_d.iadder_src    = is_load | is_store | is_jalr;

    if (is_load)                      ctrl_d.wb_mux_sel = WB_LOAD;
    else if (is_lui)                  ctrl_d.wb_mux_sel = WB_IMM;
    else if (is_auipc)                ctrl_d.wb_mux_sel = WB_IADDER;
    else if (is_csr)                  ctrl_d.wb_mux_sel = WB_CSR;
    else if (is_jal | is_jalr)        ctrl_d.wb_mux_sel = WB_PC4;
    else                              ctrl_d.wb_mux_sel = WB_ALU;

    if (is_op_imm | is_load | is_jalr | (is_system & !is_csr)) ctrl_d.imm_type = IMM_I;
    else if (is_store)                ctrl_d.imm_type = IMM_S;
    else if (is_branch)               ctrl_d.imm_type = IMM_B;
    else if (is_lui | is_auipc)       ctrl_d.imm_type = IMM_U;
    else if (is_jal)                  ctrl_d.imm_type = IMM_J;
    else if (is_csr)                  ctrl_d.imm_type = IMM_CSR;
    else                              ctrl_d.imm_type = IMM_R;

    ctrl_d.csr_op            = is_system ? funct3_in : 3'b000;
    ctrl_d.illegal_instr     = illegal;
    ctrl_d.misalligned_load  = is_load & mis_access;
    ctrl_d.misalligned_store = is_store & mis_access;

    ctrl_d.rf_wr_en   = !suppress
                      & (is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm |
                         is_csr | (is_load & !mis_access));
    ctrl_d.mem_wr_req = !suppress & is_store & !mis_access;
    ctrl_d.csr_wr_en  = !suppress & is_csr;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign alu_opcode_out        = ctrl_q.alu_opcode;
  assign mem_wr_req_out        = ctrl_q.mem_wr_req;
  assign load_size_out         = ctrl_q.load_size;
  assign load_unsigned_out     = ctrl_q.load_unsigned;
  assign alu_src_out           = ctrl_q.alu_src;
  assign iadder_src_out        = ctrl_q.iadder_src;
  assign csr_wr_en_out         = ctrl_q.csr_wr_en;
  assign rf_wr_en_out          = ctrl_q.rf_wr_en;
  assign wb_mux_sel_out        = ctrl_q.wb_mux_sel;
  assign imm_type_out          = ctrl_q.imm_type;
  assign csr_op_out            = ctrl_q.csr_op;
  assign illegal_instr_out     = ctrl_q.illegal_instr;
  assign misalligned_load_out  = ctrl_q.misalligned_load;
  assign misalligned_store_out = ctrl_q.misalligned_store;

endmodule

// File: tb/tb_msrv32_dec.sv
// Purpose : directed bench for msrv32_dec with hand-computed expected controls.
// Latency : outputs checked 1 ns after the edge that registers each vector.
// Backpr. : n/a.
module tb_msrv32_dec;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [6:0] opcode_in;
  logic       funct7_5_in;
  logic [2:0] funct3_in;
  logic [1:0] iadder_1_to_0_in;
  logic       trap_taken_in;
  logic [3:0] alu_opcode_out;
  logic       mem_wr_req_out;
  logic [1:0] load_size_out;
  logic       load_unsigned_out;
  logic       alu_src_out;
  logic       iadder_src_out;
  logic       csr_wr_en_out;
  logic       rf_wr_en_out;
  logic [2:0] wb_mux_sel_out;
  logic [2:0] imm_type_out;
  logic [2:0] csr_op_out;
  logic       illegal_instr_out;
  logic       misalligned_load_out;
  logic       misalligned_store_out;

  int checks = 0;
  int errors = 0;

  msrv32_dec dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .opcode_in            (opcode_in),
    .funct7_5_in          (funct7_5_in),
    .funct3_in            (funct3_in),
    .iadder_1_to_0_in     (iadder_1_to_0_in),
    .trap_taken_in        (trap_taken_in),
    .alu_opcode_out       (alu_opcode_out),
    .mem_wr_req_out       (mem_wr_req_out),
    .load_size_out        (load_size_out),
    .load_unsigned_out    (load_unsigned_out),
    .alu_src_out          (alu_src_out),
    .iadder_src_out       (iadder_src_out),
    .csr_wr_en_out        (csr_wr_en_out),
    .rf_wr_en_out         (rf_wr_en_out),
    .wb_mux_sel_out       (wb_mux_sel_out),
    .imm_type_out         (imm_type_out),
    .csr_op_out           (csr_op_out),
    .illegal_instr_out    (illegal_instr_out),
    .misalligned_load_out (misalligned_load_out),
    .misalligned_store_out(misalligned_store_out)
  );

  always #5 clk_in = ~clk_in;

  // All outputs flattened, for the all-zero reset checks
  logic [23:0] all_outs;
  assign all_outs = {alu_opcode_out, mem_wr_req_out, load_size_out, load_unsigned_out,
                     alu_src_out, iadder_src_out, csr_wr_en_out, rf_wr_en_out,
                     wb_mux_sel_out, imm_type_out, csr_op_out, illegal_instr_out,
                     misalligned_load_out, misalligned_store_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one vector, let it register, sample 1 ns after the edge
  task automatic apply(input logic [6:0] op, input logic f7, input logic [2:0] f3,
                       input logic [1:0] addr, input logic trap);
    opcode_in        = op;
    funct7_5_in      = f7;
    funct3_in        = f3;
    iadder_1_to_0_in = addr;
    trap_taken_in    = trap;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b0;
    apply(7'b0110011, 1'b1, 3'b101, 2'b11, 1'b0);
    apply(7'b1110011, 1'b1, 3'b001, 2'b10, 1'b1);
    check("reset_all_zero", 32'(all_outs), 32'h0);
    rst_in = 1'b1;

    // ADD/SUB with alt bit -> SUB
    apply(7'b0110011, 1'b1, 3'b000, 2'b00, 1'b0);
    check("sub_alu", 32'(alu_opcode_out), 32'b1000);
    check("sub_rf_wr", 32'(rf_wr_en_out), 32'd1);
    check("sub_alu_src", 32'(alu_src_out), 32'd1);
    check("sub_wb", 32'(wb_mux_sel_out), 32'b000);
    check("sub_imm", 32'(imm_type_out), 32'b000);
    check("sub_flags", 32'({illegal_instr_out, misalligned_load_out, misalligned_store_out}), 32'd0);
    check("sub_mem_csr", 32'({mem_wr_req_out, csr_wr_en_out}), 32'd0);

    // SRAI keeps alt bit, ADDI drops it
    apply(7'b0010011, 1'b1, 3'b101, 2'b00, 1'b0);
    check("srai_alu", 32'(alu_opcode_out), 32'b1101);
    check("srai_imm", 32'(imm_type_out), 32'b001);
    check("srai_alu_src", 32'(alu_src_out), 32'd0);
    apply(7'b0010011, 1'b1, 3'b000, 2'b00, 1'b0);
    check("addi_alu", 32'(alu_opcode_out), 32'b0000);
    check("addi_imm", 32'(imm_type_out), 32'b001);
    check("addi_alu_src", 32'(alu_src_out), 32'd0);
    check("addi_rf_wr", 32'(rf_wr_en_out), 32'd1);

    // LW alignment
    apply(7'b0000011, 1'b0, 3'b010, 2'b00, 1'b0);
    check("lw_al_misld", 32'(misalligned_load_out), 32'd0);
    check("lw_al_wb", 32'(wb_mux_sel_out), 32'b001);
    check("lw_al_rf_wr", 32'(rf_wr_en_out), 32'd1);
    check("lw_al_size", 32'({load_size_out, load_unsigned_out}), 32'b100);
    check("lw_al_iadder_src", 32'(iadder_src_out), 32'd1);
    apply(7'b0000011, 1'b0, 3'b010, 2'b10, 1'b0);
    check("lw_mis_misld", 32'(misalligned_load_out), 32'd1);
    check("lw_mis_rf_wr", 32'(rf_wr_en_out), 32'd0);
    // LHU: odd address misaligned, addr=10 fine
    apply(7'b0000011, 1'b0, 3'b101, 2'b01, 1'b0);
    check("lhu_odd_misld", 32'(misalligned_load_out), 32'd1);
    check("lhu_odd_size", 32'({load_size_out, load_unsigned_out}), 32'b011);
    apply(7'b0000011, 1'b0, 3'b101, 2'b10, 1'b0);
    check("lhu_even_misld", 32'(misalligned_load_out), 32'd0);
    check("lhu_even_rf_wr", 32'(rf_wr_en_out), 32'd1);
    // LB at odd address is fine
    apply(7'b0000011, 1'b0, 3'b000, 2'b11, 1'b0);
    check("lb_odd_misld", 32'(misalligned_load_out), 32'd0);
    // LD-like funct3=011 is illegal
    apply(7'b0000011, 1'b0, 3'b011, 2'b00, 1'b0);
    check("load_f3_011_illegal", 32'(illegal_instr_out), 32'd1);
    check("load_f3_011_rf_wr", 32'(rf_wr_en_out), 32'd0);

    // SH with trap
    apply(7'b0100011, 1'b0, 3'b001, 2'b00, 1'b0);
    check("sh_mem_wr", 32'(mem_wr_req_out), 32'd1);
    check("sh_imm", 32'(imm_type_out), 32'b010);
    check("sh_rf_wr", 32'(rf_wr_en_out), 32'd0);
    apply(7'b0100011, 1'b0, 3'b001, 2'b00, 1'b1);
    check("sh_trap_mem_wr", 32'(mem_wr_req_out), 32'd0);
    check("sh_trap_imm", 32'(imm_type_out), 32'b010);
    apply(7'b0100011, 1'b0, 3'b001, 2'b01, 1'b0);
    check("sh_mis_misst", 32'(misalligned_store_out), 32'd1);
    check("sh_mis_mem_wr", 32'(mem_wr_req_out), 32'd0);
    apply(7'b0100011, 1'b0, 3'b011, 2'b00, 1'b0);
    check("store_f3_011_illegal", 32'(illegal_instr_out), 32'd1);
    check("store_f3_011_mem_wr", 32'(mem_wr_req_out), 32'd0);

    // CSRRW, then under trap
    apply(7'b1110011, 1'b0, 3'b001, 2'b00, 1'b0);
    check("csrrw_csr_wr", 32'(csr_wr_en_out), 32'd1);
    check("csrrw_wb", 32'(wb_mux_sel_out), 32'b100);
    check("csrrw_imm", 32'(imm_type_out), 32'b110);
    check("csrrw_csr_op", 32'(csr_op_out), 32'b001);
    check("csrrw_rf_wr", 32'(rf_wr_en_out), 32'd1);
    apply(7'b1110011, 1'b0, 3'b001, 2'b00, 1'b1);
    check("csrrw_trap_wr", 32'({csr_wr_en_out, rf_wr_en_out}), 32'd0);
    check("csrrw_trap_csr_op", 32'(csr_op_out), 32'b001);
    // ECALL-type SYSTEM funct3=000
    apply(7'b1110011, 1'b0, 3'b000, 2'b00, 1'b0);
    check("ecall_imm", 32'(imm_type_out), 32'b001);
    check("ecall_wb_wr", 32'({wb_mux_sel_out, csr_wr_en_out, rf_wr_en_out}), 32'd0);
    apply(7'b1110011, 1'b0, 3'b100, 2'b00, 1'b0);
    check("system_f3_100_illegal", 32'(illegal_instr_out), 32'd1);
    check("system_f3_100_csr_wr", 32'(csr_wr_en_out), 32'd0);

    // Illegal opcode (low bits 00)
    apply(7'b0001100, 1'b0, 3'b000, 2'b00, 1'b0);
    check("badop_illegal", 32'(illegal_instr_out), 32'd1);
    check("badop_wr_en", 32'({mem_wr_req_out, rf_wr_en_out, csr_wr_en_out}), 32'd0);

    // LUI, AUIPC, JAL, JALR, BRANCH
    apply(7'b0110111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("lui_wb_imm", 32'({wb_mux_sel_out, imm_type_out}), 32'b010_100);
    check("lui_rf_wr", 32'(rf_wr_en_out), 32'd1);
    apply(7'b0010111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("auipc_wb_imm", 32'({wb_mux_sel_out, imm_type_out}), 32'b011_100);
    check("auipc_iadder_src", 32'(iadder_src_out), 32'd0);
    apply(7'b1101111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("jal_wb_imm", 32'({wb_mux_sel_out, imm_type_out}), 32'b101_101);
    apply(7'b1100111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("jalr_wb_imm_src", 32'({wb_mux_sel_out, imm_type_out, iadder_src_out}), 32'b101_001_1);
    apply(7'b1100111, 1'b0, 3'b001, 2'b00, 1'b0);
    check("jalr_f3_illegal", 32'({illegal_instr_out, rf_wr_en_out}), 32'b10);
    apply(7'b1100011, 1'b0, 3'b001, 2'b00, 1'b0);
    check("bne_ctrl", 32'({alu_src_out, imm_type_out, rf_wr_en_out, illegal_instr_out}), 32'b1_011_0_0);
    apply(7'b1100011, 1'b0, 3'b010, 2'b00, 1'b0);
    check("branch_f3_010_illegal", 32'(illegal_instr_out), 32'd1);
    // FENCE: known class, no effects
    apply(7'b0001111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("fence_ctrl", 32'({illegal_instr_out, rf_wr_en_out, wb_mux_sel_out, imm_type_out}), 32'd0);

    // Mid-operation reset
    apply(7'b0110011, 1'b1, 3'b000, 2'b00, 1'b0);
    rst_in = 1'b0;
    apply(7'b0110011, 1'b1, 3'b000, 2'b00, 1'b0);
    check("midop_reset_zero", 32'(all_outs), 32'h0);
    rst_in = 1'b1;
    apply(7'b0110011, 1'b1, 3'b000, 2'b00, 1'b0);
    check("post_reset_sub", 32'(alu_opcode_out), 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
